// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between instruction fetch and data
// memory. Data requests win over fetch; a granted access runs until the RAM
// reports ACCESS (one-cycle iHit/dHit strobe follows), ERROR, or the requester
// withdraws. The RAM port is driven combinationally from the grant state so
// that it tracks the live requester inputs and drops immediately on RST.
// Optional feature: define MEMARB_TIMEOUT_EN to enable the watchdog that
// abandons an access after TIMEOUT cycles and raises the sticky memerr flag.
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        iHit,
  output logic        dHit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        memerr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_INSTR = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  state_e      state_q, state_d;
  logic        ihit_q, ihit_d;
  logic        dhit_q, dhit_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;
  logic        dreq_s;
  logic        timeout_s;

  assign dreq_s = dREN | dWEN;

`ifdef MEMARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             memerr_q;
  logic             busy_s;
  logic             to_fire_s;

  assign busy_s    = (state_q == ST_DATA) || (state_q == ST_INSTR);
  assign timeout_s = busy_s && (cnt_q == CNT_W'(TIMEOUT - 1));
  // A genuine timeout: requester still asking, RAM neither done nor failed.
  assign to_fire_s = timeout_s && (ramstate != RAM_ACCESS) && (ramstate != RAM_ERROR) &&
                     (((state_q == ST_DATA) && dreq_s) || ((state_q == ST_INSTR) && iREN));

  // Watchdog: count cycles spent waiting on the RAM; memerr sticks until reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q    <= '0;
      memerr_q <= 1'b0;
    end else begin
      if (busy_s) begin
        cnt_q <= cnt_q + CNT_W'(1'b1);
      end else begin
        cnt_q <= '0;
      end
      if (to_fire_s) begin
        memerr_q <= 1'b1;
      end
    end
  end

  assign memerr = memerr_q;
`else
  // Watchdog absent: accesses wait indefinitely for the RAM.
  assign timeout_s = 1'b0 & (TIMEOUT > 0);
  assign memerr    = 1'b0;
`endif

  // State, hit strobes and returned data registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
      iload_q <= 32'h0000_0000;
      dload_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      ihit_q  <= ihit_d;
      dhit_q  <= dhit_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
    end
  end

  // Arbitration and access progress; a dropped request is checked first since
  // the RAM port is then no longer enabled.
  always_comb begin
    state_d = state_q;
    ihit_d  = 1'b0;
    dhit_d  = 1'b0;
    iload_d = iload_q;
    dload_d = dload_q;
    case (state_q)
      ST_IDLE: begin
        if (dreq_s) begin
          state_d = ST_DATA;
        end else if (iREN) begin
          state_d = ST_INSTR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!dreq_s) begin
          state_d = ST_IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          if (dREN) begin
            dload_d = ramload;
          end else begin
            dload_d = dload_q;
          end
          dhit_d  = 1'b1;
          state_d = ST_DONE;
        end else if ((ramstate == RAM_ERROR) || timeout_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_INSTR: begin
        if (!iREN) begin
          state_d = ST_IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          iload_d = ramload;
          ihit_d  = 1'b1;
          state_d = ST_DONE;
        end else if ((ramstate == RAM_ERROR) || timeout_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_INSTR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM port follows the live inputs of whichever side holds the grant.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    case (state_q)
      ST_DATA: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      ST_INSTR: begin
        ramREN   = 1'b1;
        ramWEN   = 1'b0;
        ramaddr  = iaddr;
        ramstore = 32'h0000_0000;
      end
      default: begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'h0000_0000;
        ramstore = 32'h0000_0000;
      end
    endcase
  end

  assign iHit  = ihit_q;
  assign dHit  = dhit_q;
  assign iload = iload_q;
  assign dload = dload_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TB_TIMEOUT = 4;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        ramREN, ramWEN, iHit, dHit, memerr;
  logic [31:0] ramaddr, ramstore, iload, dload;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_iload, exp_dload;

  mem_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .iHit(iHit), .dHit(dHit), .iload(iload), .dload(dload), .memerr(memerr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; ramstate = ACCESS;
    iaddr = 32'h10; daddr = 32'h20; dstore = 32'h30; ramload = 32'hAAAA5555;
    next_cycle(); next_cycle();
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rst_ramREN: got %b want 0", ramREN); end
    checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL rst_ramWEN: got %b want 0", ramWEN); end
    checks++; if (ramaddr !== 32'h0) begin errors++; $display("FAIL rst_ramaddr: got %h want 0", ramaddr); end
    checks++; if (ramstore !== 32'h0) begin errors++; $display("FAIL rst_ramstore: got %h want 0", ramstore); end
    checks++; if (iHit !== 1'b0 || dHit !== 1'b0) begin errors++; $display("FAIL rst_hits: got %b%b want 00", iHit, dHit); end
    checks++; if (iload !== 32'h0 || dload !== 32'h0) begin errors++; $display("FAIL rst_loads: got %h/%h want 0/0", iload, dload); end
    checks++; if (memerr !== 1'b0) begin errors++; $display("FAIL rst_memerr: got %b want 0", memerr); end
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    next_cycle();
    RST = 1'b0;
    exp_iload = 32'h0; exp_dload = 32'h0;
    next_cycle();
  endtask

  task automatic test_single_fetch();
    iREN = 1'b1; iaddr = 32'h40; ramstate = FREE;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL fetch_idle_ren: got %b want 0", ramREN); end
    next_cycle(); ramstate = BUSY;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0) begin errors++; $display("FAIL fetch_ren: got %b%b want 10", ramREN, ramWEN); end
    checks++; if (ramaddr !== 32'h40) begin errors++; $display("FAIL fetch_addr: got %h want 40", ramaddr); end
    next_cycle(); ramstate = BUSY;
    @(negedge CLK);
    checks++; if (iHit !== 1'b0) begin errors++; $display("FAIL fetch_early_hit: got %b want 0", iHit); end
    next_cycle(); ramstate = ACCESS; ramload = 32'h8C220004;
    next_cycle(); ramstate = FREE; iREN = 1'b0;
    exp_iload = 32'h8C220004;
    @(negedge CLK);
    checks++; if (iHit !== 1'b1 || dHit !== 1'b0) begin errors++; $display("FAIL fetch_hit: got i%b d%b want i1 d0", iHit, dHit); end
    checks++; if (iload !== exp_iload) begin errors++; $display("FAIL fetch_iload: got %h want %h", iload, exp_iload); end
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL fetch_done_ren: got %b want 0", ramREN); end
    next_cycle();
    @(negedge CLK);
    checks++; if (iHit !== 1'b0) begin errors++; $display("FAIL fetch_hit_len: got %b want 0", iHit); end
    checks++; if (iload !== exp_iload) begin errors++; $display("FAIL fetch_iload_hold: got %h want %h", iload, exp_iload); end
  endtask

  task automatic test_priority();
    next_cycle();
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100; ramstate = FREE;
    next_cycle(); ramstate = ACCESS; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin errors++; $display("FAIL prio_grant: got ren=%b addr=%h want 1/100", ramREN, ramaddr); end
    next_cycle(); dREN = 1'b0; ramstate = FREE;
    exp_dload = 32'hDEADBEEF;
    @(negedge CLK);
    checks++; if (dHit !== 1'b1 || iHit !== 1'b0) begin errors++; $display("FAIL prio_dhit: got d%b i%b want d1 i0", dHit, iHit); end
    checks++; if (dload !== exp_dload) begin errors++; $display("FAIL prio_dload: got %h want %h", dload, exp_dload); end
    next_cycle();
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0 || dHit !== 1'b0) begin errors++; $display("FAIL prio_gap: got ren=%b dhit=%b want 0/0", ramREN, dHit); end
    next_cycle(); ramstate = ACCESS; ramload = 32'h11112222;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h80) begin errors++; $display("FAIL prio_fetch: got ren=%b addr=%h want 1/80", ramREN, ramaddr); end
    next_cycle(); iREN = 1'b0; ramstate = FREE;
    exp_iload = 32'h11112222;
    @(negedge CLK);
    checks++; if (iHit !== 1'b1 || iload !== exp_iload) begin errors++; $display("FAIL prio_ihit: got %b/%h want 1/%h", iHit, iload, exp_iload); end
    checks++; if (dload !== exp_dload) begin errors++; $display("FAIL prio_dload_hold: got %h want %h", dload, exp_dload); end
    next_cycle();
  endtask

  task automatic test_store();
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'h12345678; ramstate = FREE;
    @(negedge CLK);
    checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL store_idle_wen: got %b want 0", ramWEN); end
    next_cycle(); ramstate = ACCESS; ramload = 32'hFFFF0000;
    @(negedge CLK);
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL store_en: got w%b r%b want w1 r0", ramWEN, ramREN); end
    checks++; if (ramaddr !== 32'h200 || ramstore !== 32'h12345678) begin errors++; $display("FAIL store_port: got %h/%h want 200/12345678", ramaddr, ramstore); end
    next_cycle(); dWEN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    checks++; if (dHit !== 1'b1 || ramWEN !== 1'b0) begin errors++; $display("FAIL store_hit: got hit=%b wen=%b want 1/0", dHit, ramWEN); end
    checks++; if (dload !== exp_dload) begin errors++; $display("FAIL store_dload: got %h want %h", dload, exp_dload); end
    next_cycle();
    @(negedge CLK);
    checks++; if (dHit !== 1'b0) begin errors++; $display("FAIL store_hit_len: got %b want 0", dHit); end
  endtask

  task automatic test_abort();
    next_cycle(); dREN = 1'b1; daddr = 32'h300; ramstate = FREE;
    next_cycle(); ramstate = BUSY;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL abort_ren: got %b want 1", ramREN); end
    next_cycle(); dREN = 1'b0;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL abort_live_ren: got %b want 0", ramREN); end
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      @(negedge CLK);
      checks++; if (dHit !== 1'b0 || ramaddr !== 32'h0) begin errors++; $display("FAIL abort_idle: got hit=%b addr=%h want 0/0", dHit, ramaddr); end
    end
  endtask

  task automatic test_error();
    next_cycle(); dREN = 1'b1; daddr = 32'h600; ramstate = FREE;
    next_cycle(); ramstate = ERROR;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL err_ren: got %b want 1", ramREN); end
    next_cycle(); ramstate = FREE;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0 || dHit !== 1'b0) begin errors++; $display("FAIL err_idle: got ren=%b hit=%b want 0/0", ramREN, dHit); end
    next_cycle(); ramstate = ACCESS; ramload = 32'h0BADF00D;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h600) begin errors++; $display("FAIL err_retry: got ren=%b addr=%h want 1/600", ramREN, ramaddr); end
    next_cycle(); dREN = 1'b0; ramstate = FREE;
    exp_dload = 32'h0BADF00D;
    @(negedge CLK);
    checks++; if (dHit !== 1'b1 || dload !== exp_dload) begin errors++; $display("FAIL err_hit: got %b/%h want 1/%h", dHit, dload, exp_dload); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    iREN = 1'b1; iaddr = 32'h500; ramstate = FREE;
    next_cycle(); ramstate = BUSY;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL rmid_ren: got %b want 1", ramREN); end
    #2; RST = 1'b1; #1;
    exp_iload = 32'h0; exp_dload = 32'h0;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rmid_async_ren: got %b want 0", ramREN); end
    checks++; if (iload !== 32'h0 || dload !== 32'h0 || iHit !== 1'b0) begin errors++; $display("FAIL rmid_clear: got %h/%h hit=%b want 0/0/0", iload, dload, iHit); end
    next_cycle(); RST = 1'b0; ramstate = FREE;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0 || iHit !== 1'b0) begin errors++; $display("FAIL rmid_post: got ren=%b hit=%b want 0/0", ramREN, iHit); end
    next_cycle(); ramstate = ACCESS; ramload = 32'hCAFEF00D;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin errors++; $display("FAIL rmid_refetch: got ren=%b addr=%h want 1/500", ramREN, ramaddr); end
    next_cycle(); iREN = 1'b0; ramstate = FREE;
    exp_iload = 32'hCAFEF00D;
    @(negedge CLK);
    checks++; if (iHit !== 1'b1 || iload !== exp_iload) begin errors++; $display("FAIL rmid_hit: got %b/%h want 1/%h", iHit, iload, exp_iload); end
    next_cycle();
  endtask

`ifdef MEMARB_TIMEOUT_EN
  task automatic test_timeout();
    iREN = 1'b1; iaddr = 32'h700; ramstate = BUSY;
    for (int k = 0; k < TB_TIMEOUT; k++) begin
      next_cycle();
      @(negedge CLK);
      checks++; if (ramREN !== 1'b1 || memerr !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got ren=%b err=%b want 1/0", k, ramREN, memerr); end
    end
    next_cycle(); iREN = 1'b0;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0 || iHit !== 1'b0 || memerr !== 1'b1) begin errors++; $display("FAIL to_fire: got ren=%b hit=%b err=%b want 0/0/1", ramREN, iHit, memerr); end
    next_cycle(); dREN = 1'b1; daddr = 32'h800; ramstate = FREE;
    next_cycle(); ramstate = ACCESS; ramload = 32'h55AA55AA;
    next_cycle(); dREN = 1'b0; ramstate = FREE;
    exp_dload = 32'h55AA55AA;
    @(negedge CLK);
    checks++; if (dHit !== 1'b1 || dload !== exp_dload) begin errors++; $display("FAIL to_next: got %b/%h want 1/%h", dHit, dload, exp_dload); end
    checks++; if (memerr !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", memerr); end
    next_cycle();
  endtask
`else
  task automatic test_no_timeout();
    iREN = 1'b1; iaddr = 32'h900; ramstate = BUSY;
    for (int k = 0; k < 70; k++) begin
      next_cycle();
      @(negedge CLK);
      checks++; if (ramREN !== 1'b1 || memerr !== 1'b0 || iHit !== 1'b0) begin errors++; $display("FAIL nto_wait%0d: got ren=%b err=%b hit=%b want 1/0/0", k, ramREN, memerr, iHit); end
    end
    next_cycle(); ramstate = ACCESS; ramload = 32'h13579BDF;
    next_cycle(); iREN = 1'b0; ramstate = FREE;
    exp_iload = 32'h13579BDF;
    @(negedge CLK);
    checks++; if (iHit !== 1'b1 || iload !== exp_iload) begin errors++; $display("FAIL nto_hit: got %b/%h want 1/%h", iHit, iload, exp_iload); end
    next_cycle();
  endtask
`endif

  // Random traffic against a transaction model: who owns the RAM, whether the
  // one-cycle completion gap is in progress, and the last returned data.
  task automatic test_random();
    int          owner;      // 0 none, 1 data side, 2 fetch side
    bit          gap;
    int          waited;
    int          r;
    bit          live;
    logic        m_ihit, m_dhit, m_err;
    logic [31:0] m_iload, m_dload;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    next_cycle(); RST = 1'b0;
    owner = 0; gap = 1'b0; waited = 0; m_ihit = 1'b0; m_dhit = 1'b0; m_err = 1'b0;
    m_iload = 32'h0; m_dload = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      // Apply the edge just taken using the inputs held through the last cycle.
      m_ihit = 1'b0; m_dhit = 1'b0;
      if (gap) begin
        gap = 1'b0;
      end else if (owner == 0) begin
        if (dREN || dWEN) begin owner = 1; waited = 0; end
        else if (iREN) begin owner = 2; waited = 0; end
      end else begin
        live = (owner == 1) ? (dREN || dWEN) : iREN;
        if (!live) owner = 0;
        else if (ramstate == ACCESS) begin
          if (owner == 1) begin m_dhit = 1'b1; if (dREN) m_dload = ramload; end
          else begin m_ihit = 1'b1; m_iload = ramload; end
          owner = 0; gap = 1'b1;
        end
        else if (ramstate == ERROR) owner = 0;
`ifdef MEMARB_TIMEOUT_EN
        else if (waited == TB_TIMEOUT - 1) begin owner = 0; m_err = 1'b1; end
`endif
        else waited++;
      end
      // New requester and RAM behaviour for this cycle.
      if (iREN) begin
        if ($urandom_range(0, 99) < (m_ihit ? 70 : 15)) iREN = 1'b0;
      end else if ($urandom_range(0, 99) < 35) iREN = 1'b1;
      if (dREN || dWEN) begin
        if ($urandom_range(0, 99) < (m_dhit ? 70 : 15)) begin dREN = 1'b0; dWEN = 1'b0; end
      end else if ($urandom_range(0, 99) < 30) begin
        if ($urandom_range(0, 1) == 1) dREN = 1'b1; else dWEN = 1'b1;
      end
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      r = $urandom_range(0, 99);
      ramstate = (r < 15) ? FREE : (r < 50) ? BUSY : (r < 85) ? ACCESS : ERROR;
      if (ramstate == ACCESS && ((owner == 1 && !(dREN || dWEN)) || (owner == 2 && !iREN))) ramstate = BUSY;
      e_ren = 1'b0; e_wen = 1'b0; e_addr = 32'h0; e_store = 32'h0;
      if (owner == 1) begin e_ren = dREN; e_wen = dWEN; e_addr = daddr; e_store = dstore; end
      else if (owner == 2) begin e_ren = 1'b1; e_addr = iaddr; end
      @(negedge CLK);
      checks++; if (ramREN !== e_ren || ramWEN !== e_wen) begin errors++; $display("FAIL rnd_en c%0d: got r%b w%b want r%b w%b", c, ramREN, ramWEN, e_ren, e_wen); end
      checks++; if (ramaddr !== e_addr) begin errors++; $display("FAIL rnd_addr c%0d: got %h want %h", c, ramaddr, e_addr); end
      checks++; if (ramstore !== e_store) begin errors++; $display("FAIL rnd_store c%0d: got %h want %h", c, ramstore, e_store); end
      checks++; if (iHit !== m_ihit || dHit !== m_dhit) begin errors++; $display("FAIL rnd_hit c%0d: got i%b d%b want i%b d%b", c, iHit, dHit, m_ihit, m_dhit); end
      checks++; if (iload !== m_iload) begin errors++; $display("FAIL rnd_iload c%0d: got %h want %h", c, iload, m_iload); end
      checks++; if (dload !== m_dload) begin errors++; $display("FAIL rnd_dload c%0d: got %h want %h", c, dload, m_dload); end
      checks++; if (memerr !== m_err) begin errors++; $display("FAIL rnd_memerr c%0d: got %b want %b", c, memerr, m_err); end
      checks++; if (iHit === 1'b1 && dHit === 1'b1) begin errors++; $display("FAIL rnd_excl c%0d: got both hits want at most one", c); end
    end
  endtask

  initial begin
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0;
    exp_iload = 32'h0; exp_dload = 32'h0;
    test_reset();
    test_single_fetch();
    test_priority();
    test_store();
    test_abort();
    test_error();
    test_reset_mid();
`ifdef MEMARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
